// File: rtl/qspi_master_pkg.sv
// qspi_master_pkg
//   Shared definitions for the ice40 <-> STM32 quad-SPI initiator: FSM state
//   encoding, header layout, idle pad levels and frame-length helpers.
//   Imported by qspi_clkgen and qspi_master.

package qspi_master_pkg;

   // Frame sequencer states.
   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StSetup = 2'd1,
      StShift = 2'd2,
      StGap   = 2'd3
   } qspi_state_e;

   // Header byte is {rw, addr[6:0]}; rw sits in the top bit.
   localparam int unsigned HdrNibbles = 2;
   localparam int unsigned HdrRwBit   = 7;

   // Idle pad levels: select deasserted, clock low (mode 0).
   localparam logic QssIdle = 1'b1;
   localparam logic QckIdle = 1'b0;

   // QCK cycles in a write frame (header plus payload nibbles).
   function automatic int unsigned write_cycles(input int unsigned data_bytes);
      return HdrNibbles + 2 * data_bytes;
   endfunction

   // QCK cycles in a read frame (header, turnaround, payload nibbles).
   function automatic int unsigned read_cycles(input int unsigned data_bytes,
                                               input int unsigned turn_cycles);
      return HdrNibbles + turn_cycles + 2 * data_bytes;
   endfunction

   function automatic int unsigned max_cycles(input int unsigned data_bytes,
                                              input int unsigned turn_cycles);
      int unsigned wr;
      int unsigned rd;
      wr = write_cycles(data_bytes);
      rd = read_cycles(data_bytes, turn_cycles);
      return (wr > rd) ? wr : rd;
   endfunction

endpackage

// File: rtl/qspi_clkgen.sv
// qspi_clkgen
//   Phase timer and QCK generator. A CLK_DIV-cycle counter runs while the
//   sequencer is active; each terminal count ends one QCK half-period.
//
//   Ports:
//     CLK, reset_in  system clock, asynchronous active-high reset
//     cnt_en         run the phase counter (any non-idle state)
//     qck_en         allow QCK to toggle (SETUP/SHIFT); QCK forced low otherwise
//     hold_low       suppress the next rise (final hold phase of a frame)
//     phase_end      current half-period ends on this edge
//     rise_stb       QCK goes high on this edge
//     fall_stb       QCK goes low on this edge
//     qck            registered QCK level

module qspi_clkgen
   import qspi_master_pkg::*;
#(
   parameter int unsigned CLK_DIV = 2
) (
   input  logic CLK,
   input  logic reset_in,
   input  logic cnt_en,
   input  logic qck_en,
   input  logic hold_low,
   output logic phase_end,
   output logic rise_stb,
   output logic fall_stb,
   output logic qck
);

   localparam int unsigned     CntW    = $clog2(CLK_DIV) + 1;
   localparam logic [CntW-1:0] CntLast = CntW'(CLK_DIV - 1);

   logic [CntW-1:0] cnt_q, cnt_d;
   logic            qck_q, qck_d;

   always_comb begin
      phase_end = cnt_en && (cnt_q == CntLast);
      rise_stb  = phase_end && qck_en && !qck_q && !hold_low;
      fall_stb  = phase_end && qck_en && qck_q;

      // Counter wraps on every terminal count so consecutive phases
      // (including SHIFT->GAP and GAP->SETUP) need no restart.
      cnt_d = cnt_q;
      if (!cnt_en || phase_end) begin
         cnt_d = '0;
      end else begin
         cnt_d = cnt_q + 1'b1;
      end

      qck_d = qck_q;
      if (!qck_en) begin
         qck_d = QckIdle;
      end else if (rise_stb) begin
         qck_d = 1'b1;
      end else if (fall_stb) begin
         qck_d = 1'b0;
      end
   end

   always_ff @(posedge CLK or posedge reset_in) begin
      if (reset_in) begin
         cnt_q <= '0;
         qck_q <= QckIdle;
      end else begin
         cnt_q <= cnt_d;
         qck_q <= qck_d;
      end
   end

   assign qck = qck_q;

endmodule

// File: rtl/qspi_master.sv
// qspi_master
//   Quad-SPI initiator for the ice40 <-> STM32 link. Accepts one read or write
//   command at a time, sends it as a nibble frame on QD[3:0] (header
//   {rw, addr} then payload, byte 0 first, high nibble first) and returns read
//   data with a one-cycle rsp_valid pulse when QSS rises. The qd_read/qd_write/
//   qd_oe triple maps onto an SB_IO PIN_TYPE 6'b101001 array in the board top.
//
//   Ports:
//     CLK, reset_in            system clock, asynchronous active-high reset
//     cmd_valid/cmd_ready      command handshake
//     cmd_read, cmd_addr       1 = read; 7-bit register address
//     cmd_wdata                write payload, byte 0 in [7:0]
//     rsp_valid, rsp_data      read completion pulse; data held until next read
//     qss, qck                 slave select (active low), serial clock (idle low)
//     qd_read/qd_write/qd_oe   QD pad input, output and output enable
//     busy                     high from accept through the end of the gap

module qspi_master
   import qspi_master_pkg::*;
#(
   parameter int unsigned CLK_DIV     = 2,
   parameter int unsigned DATA_BYTES  = 4,
   parameter int unsigned TURN_CYCLES = 2
) (
   input  logic                    CLK,
   input  logic                    reset_in,
   input  logic                    cmd_valid,
   output logic                    cmd_ready,
   input  logic                    cmd_read,
   input  logic [6:0]              cmd_addr,
   input  logic [8*DATA_BYTES-1:0] cmd_wdata,
   output logic                    rsp_valid,
   output logic [8*DATA_BYTES-1:0] rsp_data,
   output logic                    qss,
   output logic                    qck,
   input  logic [3:0]              qd_read,
   output logic [3:0]              qd_write,
   output logic [3:0]              qd_oe,
   output logic                    busy
);

   localparam int unsigned DataW     = 8 * DATA_BYTES;
   localparam int unsigned FrameW    = 8 + DataW;
   localparam int unsigned NibW      = $clog2(max_cycles(DATA_BYTES, TURN_CYCLES)) + 1;

   localparam logic [NibW-1:0] WrLast    = NibW'(write_cycles(DATA_BYTES));
   localparam logic [NibW-1:0] RdLast    = NibW'(read_cycles(DATA_BYTES, TURN_CYCLES));
   localparam logic [NibW-1:0] HdrLast   = NibW'(HdrNibbles - 1);
   localparam logic [NibW-1:0] DataFirst = NibW'(HdrNibbles + TURN_CYCLES);

   // Reverse byte order: puts byte 0 at the top of the outgoing shift register,
   // and moves the first received byte into [7:0] on the way back.
   function automatic logic [DataW-1:0] byte_rev(input logic [DataW-1:0] v);
      logic [DataW-1:0] r;
      for (int i = 0; i < int'(DATA_BYTES); i++) begin
         r[8*i +: 8] = v[DataW-8-8*i +: 8];
      end
      return r;
   endfunction

   qspi_state_e         state_q, state_d;
   logic [NibW-1:0]     nib_q, nib_d;        // index of the current QCK cycle
   logic                rd_q, rd_d;
   logic [FrameW-1:0]   sr_q, sr_d;          // outgoing nibbles, next one on top
   logic [DataW-1:0]    rx_q, rx_d;          // received nibbles in arrival order
   logic                oe_q, oe_d;
   logic                qss_q, qss_d;
   logic                rsp_valid_q, rsp_valid_d;
   logic [DataW-1:0]    rsp_data_q, rsp_data_d;
   logic                ready_en_q;          // keeps cmd_ready low while in reset

   logic                cnt_en, qck_en, hold_low;
   logic                phase_end, rise_stb, fall_stb;
   logic                accept;
   logic [7:0]          hdr;

   assign cnt_en   = (state_q != StIdle);
   assign qck_en   = (state_q == StSetup) || (state_q == StShift);
   assign hold_low = (state_q == StShift) && (nib_q == (rd_q ? RdLast : WrLast));

   // Ready in IDLE and on the last gap cycle, so back-to-back frames keep
   // QSS high for exactly CLK_DIV cycles.
   assign cmd_ready = ready_en_q &&
                      ((state_q == StIdle) || ((state_q == StGap) && phase_end));
   assign accept    = cmd_valid && cmd_ready;

   qspi_clkgen #(
      .CLK_DIV (CLK_DIV)
   ) u_clkgen (
      .CLK       (CLK),
      .reset_in  (reset_in),
      .cnt_en    (cnt_en),
      .qck_en    (qck_en),
      .hold_low  (hold_low),
      .phase_end (phase_end),
      .rise_stb  (rise_stb),
      .fall_stb  (fall_stb),
      .qck       (qck)
   );

   always_comb begin
      state_d     = state_q;
      nib_d       = nib_q;
      rd_d        = rd_q;
      sr_d        = sr_q;
      rx_d        = rx_q;
      oe_d        = oe_q;
      qss_d       = qss_q;
      rsp_valid_d = 1'b0;
      rsp_data_d  = rsp_data_q;

      hdr                   = '0;
      hdr[HdrRwBit]         = cmd_read;
      hdr[HdrRwBit-1:0]     = cmd_addr;

      unique case (state_q)
         StIdle: begin
            if (accept) begin
               state_d = StSetup;
            end
         end

         StSetup: begin
            if (rise_stb) begin
               state_d = StShift;
            end
         end

         StShift: begin
            if (rise_stb && rd_q && (nib_q >= DataFirst)) begin
               rx_d = {rx_q[DataW-5:0], qd_read};
            end
            if (fall_stb) begin
               nib_d = nib_q + 1'b1;
               sr_d  = sr_q << 4;
               // Release the bus as the last header nibble ends.
               if (rd_q && (nib_q == HdrLast)) begin
                  oe_d = 1'b0;
               end
            end
            if (phase_end && hold_low) begin
               state_d = StGap;
               qss_d   = QssIdle;
               if (rd_q) begin
                  rsp_valid_d = 1'b1;
                  rsp_data_d  = byte_rev(rx_q);
               end
            end
         end

         StGap: begin
            if (phase_end && !accept) begin
               state_d = StIdle;
               oe_d    = 1'b0;
            end else if (phase_end) begin
               state_d = StSetup;
            end
         end

         default: begin
            state_d = StIdle;
         end
      endcase

      // Command capture is shared by IDLE and the last gap cycle.
      if (accept) begin
         nib_d = '0;
         rd_d  = cmd_read;
         oe_d  = 1'b1;
         qss_d = ~QssIdle;
         sr_d  = {hdr, cmd_read ? {DataW{1'b0}} : byte_rev(cmd_wdata)};
      end
   end

   always_ff @(posedge CLK or posedge reset_in) begin
      if (reset_in) begin
         state_q     <= StIdle;
         nib_q       <= '0;
         rd_q        <= 1'b0;
         sr_q        <= '0;
         rx_q        <= '0;
         oe_q        <= 1'b0;
         qss_q       <= QssIdle;
         rsp_valid_q <= 1'b0;
         rsp_data_q  <= '0;
         ready_en_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         nib_q       <= nib_d;
         rd_q        <= rd_d;
         sr_q        <= sr_d;
         rx_q        <= rx_d;
         oe_q        <= oe_d;
         qss_q       <= qss_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_data_q  <= rsp_data_d;
         ready_en_q  <= 1'b1;
      end
   end

   // Shifted-out bits fill with zero, so QD idles at 0 after the header of a
   // read and after the last nibble of a write.
   assign qd_write  = sr_q[FrameW-1 -: 4];
   assign qd_oe     = {4{oe_q}};
   assign qss       = qss_q;
   assign busy      = (state_q != StIdle);
   assign rsp_valid = rsp_valid_q;
   assign rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_qspi_master.sv
module tb_qspi_master;

   localparam int unsigned DIV  = 2;
   localparam int unsigned DB   = 4;
   localparam int unsigned TURN = 2;

   logic CLK = 1'b0;
   logic reset_in;
   always #5 CLK = ~CLK;

   // DUT A: default parameters
   logic        a_valid, a_ready, a_read, a_rsp_valid, a_qss, a_qck, a_busy;
   logic [6:0]  a_addr;
   logic [31:0] a_wdata, a_rsp_data;
   logic [3:0]  a_qd_read = 4'h0;
   logic [3:0]  a_qd_write, a_qd_oe;

   // DUT B: CLK_DIV=1, DATA_BYTES=1
   logic        b_valid, b_ready, b_read, b_rsp_valid, b_qss, b_qck, b_busy;
   logic [6:0]  b_addr;
   logic [7:0]  b_wdata, b_rsp_data;
   logic [3:0]  b_qd_read;
   logic [3:0]  b_qd_write, b_qd_oe;

   qspi_master #(.CLK_DIV(DIV), .DATA_BYTES(DB), .TURN_CYCLES(TURN)) u_dut_a (
      .CLK(CLK), .reset_in(reset_in), .cmd_valid(a_valid), .cmd_ready(a_ready),
      .cmd_read(a_read), .cmd_addr(a_addr), .cmd_wdata(a_wdata),
      .rsp_valid(a_rsp_valid), .rsp_data(a_rsp_data), .qss(a_qss), .qck(a_qck),
      .qd_read(a_qd_read), .qd_write(a_qd_write), .qd_oe(a_qd_oe), .busy(a_busy)
   );

   qspi_master #(.CLK_DIV(1), .DATA_BYTES(1), .TURN_CYCLES(TURN)) u_dut_b (
      .CLK(CLK), .reset_in(reset_in), .cmd_valid(b_valid), .cmd_ready(b_ready),
      .cmd_read(b_read), .cmd_addr(b_addr), .cmd_wdata(b_wdata),
      .rsp_valid(b_rsp_valid), .rsp_data(b_rsp_data), .qss(b_qss), .qck(b_qck),
      .qd_read(b_qd_read), .qd_write(b_qd_write), .qd_oe(b_qd_oe), .busy(b_busy)
   );

   typedef struct {
      int unsigned qss_len;
      int unsigned oe_lo_len;
      bit          rd;
      logic [31:0] rsp;
   } frame_t;

   frame_t      exp_frames[$];
   logic [3:0]  exp_nib[$];
   int          n_checks = 0;
   int          n_fail   = 0;
   logic [31:0] slave_word = 32'h04030201;   // slave sends bytes 01,02,03,04

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Scoreboard push: expected nibbles at rising QCK and frame-level timing.
   task automatic expect_frame(input bit rd, input logic [6:0] addr, input logic [31:0] wd);
      frame_t      f;
      int unsigned q;
      logic [7:0]  hdr;
      hdr = {rd, addr};
      exp_nib.push_back(hdr[7:4]);
      exp_nib.push_back(hdr[3:0]);
      if (!rd) begin
         for (int b = 0; b < int'(DB); b++) begin
            exp_nib.push_back(wd[8*b+4 +: 4]);
            exp_nib.push_back(wd[8*b +: 4]);
         end
      end
      q = rd ? (2 + TURN + 2 * DB) : (2 + 2 * DB);
      f.qss_len   = DIV * (1 + 2 * q);
      // oe drops after SETUP + nibble 0 + high half of nibble 1 = 4*DIV cycles
      f.oe_lo_len = rd ? (f.qss_len - 4 * DIV) : 0;
      f.rd        = rd;
      f.rsp       = 32'h04030201;
      exp_frames.push_back(f);
   endtask

   // ---------------------------------------------------------------- monitor A
   int   rises = 0, lo_cnt = 0, oe_lo_cnt = 0, hi_cnt = 0;
   int   last_gap = 0, frames_done = 0, rsp_cnt = 0;
   logic qck_p = 1'b0, qss_p = 1'b1;

   always @(negedge CLK) begin
      if (reset_in) begin
         rises = 0; lo_cnt = 0; oe_lo_cnt = 0; hi_cnt = 0;
         qck_p = 1'b0; qss_p = 1'b1; a_qd_read = 4'h0;
      end else begin
         if (a_qss == 1'b0) begin
            if (qss_p) last_gap = hi_cnt;
            lo_cnt++;
            if (a_qd_oe == 4'h0) oe_lo_cnt++;
            if (a_qck && !qck_p) begin
               rises++;
               if (a_qd_oe == 4'hF) begin
                  if (exp_nib.size() == 0) check("nib_extra", 32'd1, 32'd0);
                  else check("qd_nibble", {28'd0, a_qd_write}, {28'd0, exp_nib.pop_front()});
               end
            end
            if (!a_qck && qck_p) begin
               int j;
               j = rises - int'(2 + TURN);
               if (j >= 0 && j < int'(2 * DB))
                  a_qd_read = (j % 2 == 0) ? slave_word[8*(j/2)+4 +: 4] : slave_word[8*(j/2) +: 4];
               else
                  a_qd_read = 4'h0;
            end
         end else begin
            if (!qss_p) begin
               frames_done++;
               if (exp_frames.size() == 0) begin
                  check("frame_extra", 32'd1, 32'd0);
               end else begin
                  frame_t f;
                  f = exp_frames.pop_front();
                  check("qss_low_len", lo_cnt, f.qss_len);
                  check("oe_low_len", oe_lo_cnt, f.oe_lo_len);
                  check("nib_left", exp_nib.size(), 0);
                  check("rsp_valid_at_qss_rise", {31'd0, a_rsp_valid}, {31'd0, f.rd});
                  if (f.rd) check("rsp_data", a_rsp_data, f.rsp);
               end
               rises = 0; lo_cnt = 0; oe_lo_cnt = 0; hi_cnt = 0;
            end
            hi_cnt++;
         end
         if (a_rsp_valid) rsp_cnt++;
         qck_p = a_qck;
         qss_p = a_qss;
      end
   end

   // ---------------------------------------------------------------- stimulus
   task automatic issue(input bit rd, input logic [6:0] addr, input logic [31:0] wd,
                        input bit keep);
      int k = 0;
      a_read = rd; a_addr = addr; a_wdata = wd; a_valid = 1'b1;
      while (!a_ready && k < 400) begin
         @(negedge CLK);
         k++;
      end
      check("accept", {31'd0, a_ready}, 32'd1);
      if (a_ready) expect_frame(rd, addr, wd);
      @(posedge CLK);
      @(negedge CLK);
      if (!keep) a_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int k = 0;
      while ((a_busy || exp_frames.size() != 0) && k < 1000) begin
         @(negedge CLK);
         k++;
      end
      check("idle_reached", {31'd0, a_busy}, 32'd0);
      check("frames_left", exp_frames.size(), 0);
   endtask

   initial begin
      int          f0, r0, k, b_lo, b_oe_lo;
      logic        bqp;
      logic [3:0]  got[$];
      logic [3:0]  b_exp[4];

      reset_in = 1'b1;
      a_valid = 0; a_read = 0; a_addr = '0; a_wdata = '0;
      b_valid = 0; b_read = 0; b_addr = '0; b_wdata = '0; b_qd_read = 4'h0;
      repeat (2) @(negedge CLK);

      // reset values
      check("rst_qss", {31'd0, a_qss}, 32'd1);
      check("rst_qck", {31'd0, a_qck}, 32'd0);
      check("rst_qd_write", {28'd0, a_qd_write}, 32'd0);
      check("rst_qd_oe", {28'd0, a_qd_oe}, 32'd0);
      check("rst_ready", {31'd0, a_ready}, 32'd0);
      check("rst_busy", {31'd0, a_busy}, 32'd0);
      check("rst_rsp_valid", {31'd0, a_rsp_valid}, 32'd0);
      check("rst_rsp_data", a_rsp_data, 32'd0);
      reset_in = 1'b0;
      @(negedge CLK);
      check("ready_after_rst", {31'd0, a_ready}, 32'd1);

      // write 0x12 / DEADBEEF
      issue(1'b0, 7'h12, 32'hDEADBEEF, 1'b0);
      wait_idle();

      // read 0x05
      r0 = rsp_cnt;
      issue(1'b1, 7'h05, 32'h0, 1'b0);
      wait_idle();
      check("rsp_pulse_count", rsp_cnt - r0, 1);
      check("rsp_data_held", a_rsp_data, 32'h04030201);

      // back-to-back writes with cmd_valid held high
      f0 = frames_done;
      issue(1'b0, 7'h21, 32'h11223344, 1'b1);
      issue(1'b0, 7'h22, 32'h55667788, 1'b0);
      wait_idle();
      check("b2b_gap", last_gap, DIV);
      check("b2b_frames", frames_done - f0, 2);

      // reset during read data nibble 3
      issue(1'b1, 7'h05, 32'h0, 1'b0);
      k = 0;
      while (rises < int'(2 + TURN + 3) && k < 400) begin
         @(negedge CLK);
         k++;
      end
      check("reach_nibble3", {31'd0, rises >= int'(2 + TURN + 3)}, 32'd1);
      @(negedge CLK);
      r0 = rsp_cnt;
      reset_in = 1'b1;
      #1;
      check("mid_rst_qss", {31'd0, a_qss}, 32'd1);
      check("mid_rst_qck", {31'd0, a_qck}, 32'd0);
      check("mid_rst_oe", {28'd0, a_qd_oe}, 32'd0);
      check("mid_rst_qd_write", {28'd0, a_qd_write}, 32'd0);
      check("mid_rst_busy", {31'd0, a_busy}, 32'd0);
      check("mid_rst_ready", {31'd0, a_ready}, 32'd0);
      exp_frames.delete();
      exp_nib.delete();
      repeat (2) @(negedge CLK);
      reset_in = 1'b0;
      #1;
      check("ready_low_at_release", {31'd0, a_ready}, 32'd0);
      @(negedge CLK);
      check("ready_one_cycle_after", {31'd0, a_ready}, 32'd1);
      check("no_rsp_after_abort", rsp_cnt - r0, 0);
      check("rsp_data_cleared", a_rsp_data, 32'd0);
      issue(1'b0, 7'h33, 32'h12345678, 1'b0);
      wait_idle();

      // cmd_valid pulsed while busy, wdata changed mid-frame
      f0 = frames_done;
      issue(1'b0, 7'h41, 32'hCAFEF00D, 1'b0);
      a_valid = 1'b1; a_addr = 7'h7E; a_wdata = 32'hFFFFFFFF;
      @(negedge CLK);
      a_valid = 1'b0;
      repeat (6) @(negedge CLK);
      a_wdata = 32'h00000000;
      wait_idle();
      repeat (20) @(negedge CLK);
      check("busy_pulse_frames", frames_done - f0, 1);
      check("busy_pulse_qss_idle", {31'd0, a_qss}, 32'd1);

      // DUT B: CLK_DIV=1, DATA_BYTES=1 write 0x7F / 0xA5
      b_exp[0] = 4'h7; b_exp[1] = 4'hF; b_exp[2] = 4'hA; b_exp[3] = 4'h5;
      b_read = 1'b0; b_addr = 7'h7F; b_wdata = 8'hA5; b_valid = 1'b1;
      k = 0;
      while (!b_ready && k < 50) begin
         @(negedge CLK);
         k++;
      end
      check("b_accept", {31'd0, b_ready}, 32'd1);
      @(posedge CLK);
      @(negedge CLK);
      b_valid = 1'b0;
      b_lo = 0; b_oe_lo = 0; bqp = 1'b0; k = 0;
      while (k < 60 && !(b_qss && b_lo > 0)) begin
         if (!b_qss) begin
            b_lo++;
            if (b_qd_oe != 4'hF) b_oe_lo++;
            if (b_qck && !bqp) got.push_back(b_qd_write);
         end
         bqp = b_qck;
         @(negedge CLK);
         k++;
      end
      check("b_qss_low_len", b_lo, 9);
      check("b_oe_low", b_oe_lo, 0);
      check("b_nib_count", got.size(), 4);
      for (int i = 0; i < 4; i++) begin
         check("b_nibble", {28'd0, (i < got.size()) ? got[i] : 4'hx}, {28'd0, b_exp[i]});
      end
      repeat (4) @(negedge CLK);
      check("b_idle", {31'd0, b_busy}, 32'd0);
      check("b_no_rsp", {23'd0, b_rsp_valid, b_rsp_data}, 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
